// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX byte channel among NUM_REQ requesters.
// Grants are held per message, capped at MAX_BURST bytes, and reclaimed by an idle watchdog.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int MAX_BURST    = 16,
    parameter int IDLE_TIMEOUT = 255
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [8*NUM_REQ-1:0]       req_data,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [7:0]                 tx_data,
    output logic                       tx_valid,
    input  logic                       tx_ready,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       grant_active,
    output logic                       timeout_evt
);
    localparam int IDW = $clog2(NUM_REQ);
    localparam int IW1 = IDW + 1;
    localparam int BCW = $clog2(MAX_BURST + 1);
    localparam int ICW = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;
    localparam logic [BCW-1:0] BURST_LAST = BCW'(MAX_BURST - 1);
    localparam logic [ICW-1:0] IDLE_LAST  = ICW'((IDLE_TIMEOUT > 0) ? IDLE_TIMEOUT - 1 : 0);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] grant_id_q, grant_id_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0] pick;
    logic [BCW-1:0] byte_cnt_q, byte_cnt_d;
    logic [ICW-1:0] idle_cnt_q, idle_cnt_d;
    logic           timeout_q, timeout_d;
    logic           own_vld, own_last, accept, idle_end, release_g;

    // Scan offsets downward so the requester closest at/after rr_ptr wins.
    always_comb begin
        logic [IW1-1:0] idx;
        idx  = '0;
        pick = rr_ptr_q;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = {1'b0, rr_ptr_q} + IW1'(k);
            if (idx >= IW1'(NUM_REQ)) idx = idx - IW1'(NUM_REQ);
            if (req_valid[idx[IDW-1:0]]) pick = idx[IDW-1:0];
        end
    end

    assign own_vld   = req_valid[grant_id_q];
    assign own_last  = req_last[grant_id_q];
    assign accept    = (state_q == GRANT) && own_vld && tx_ready;
    assign idle_end  = (IDLE_TIMEOUT != 0) && (state_q == GRANT) && !own_vld
                       && (idle_cnt_q == IDLE_LAST);
    assign release_g = (accept && (own_last || (byte_cnt_q == BURST_LAST))) || idle_end;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            grant_id_q <= '0;
            rr_ptr_q   <= '0;
            byte_cnt_q <= '0;
            idle_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_id_q <= grant_id_d;
            rr_ptr_q   <= rr_ptr_d;
            byte_cnt_q <= byte_cnt_d;
            idle_cnt_q <= idle_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_id_d = grant_id_q;
        rr_ptr_d   = rr_ptr_q;
        byte_cnt_d = byte_cnt_q;
        idle_cnt_d = idle_cnt_q;
        timeout_d  = idle_end;
        if (state_q == IDLE) begin
            if (|req_valid) begin
                state_d    = GRANT;
                grant_id_d = pick;
                byte_cnt_d = '0;
                idle_cnt_d = '0;
            end
        end else begin
            if (accept) begin
                byte_cnt_d = byte_cnt_q + BCW'(1);
                idle_cnt_d = '0;
            end else if (!own_vld && (IDLE_TIMEOUT != 0)) begin
                idle_cnt_d = idle_cnt_q + ICW'(1);
            end
            // Hand priority to the next index so the releasing owner goes last.
            if (release_g) begin
                state_d  = IDLE;
                rr_ptr_d = (grant_id_q == IDW'(NUM_REQ - 1)) ? '0 : grant_id_q + IDW'(1);
            end
        end
    end

    always_comb begin
        tx_data   = '0;
        tx_valid  = 1'b0;
        req_ready = '0;
        if (state_q == GRANT) begin
            tx_data               = req_data[{grant_id_q, 3'b000} +: 8];
            tx_valid              = own_vld;
            req_ready[grant_id_q] = tx_ready;
        end
    end

    assign grant_id     = grant_id_q;
    assign grant_active = (state_q == GRANT);
    assign timeout_evt  = timeout_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: queue-driven requesters, a cycle-level reference model
// of the arbitration rules, a per-requester byte scoreboard and literal timing checks.
module tb_uart_tx_arbiter;
    localparam int N  = 4;
    localparam int MB = 16;
    localparam int IT = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_valid, req_last, req_ready;
    logic [7:0]     tx_data;
    logic           tx_valid, tx_ready;
    logic [1:0]     grant_id;
    logic           grant_active, timeout_evt;

    uart_tx_arbiter #(.NUM_REQ(N), .MAX_BURST(MB), .IDLE_TIMEOUT(IT)) dut (
        .clk(clk), .rst(rst), .req_data(req_data), .req_valid(req_valid),
        .req_last(req_last), .req_ready(req_ready), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .grant_id(grant_id),
        .grant_active(grant_active), .timeout_evt(timeout_evt)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    typedef struct packed {
        logic [7:0] gap;
        logic       last;
        logic [7:0] dat;
    } ent_t;

    ent_t       src_q[N][$];
    logic [7:0] exp_q[N][$];
    int         acc_cnt[N];
    int         cyc = 0;
    int         log_cyc[$], log_src[$], log_dat[$];
    int         gnt_cyc[$], gnt_id[$], rel_cyc[$], tev_cyc[$];
    int         exp_src[$], exp_dat[$], exp_cyc[$];

    task automatic push(input int r, input int dat, input bit last, input int gap);
        ent_t e;
        e.gap  = 8'(gap);
        e.last = last;
        e.dat  = 8'(dat);
        src_q[r].push_back(e);
        exp_q[r].push_back(8'(dat));
    endtask

    // Requesters: present the queue head (after an optional gap), pop on acceptance.
    initial begin : driver
        int seen_cnt[N];
        int gap_left[N];
        bit loaded[N];
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        for (int i = 0; i < N; i++) begin
            seen_cnt[i] = 0;
            gap_left[i] = 0;
            loaded[i]   = 1'b0;
        end
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (acc_cnt[i] != seen_cnt[i]) begin
                    seen_cnt[i] = acc_cnt[i];
                    src_q[i].delete(0);
                    loaded[i] = 1'b0;
                end
                if (src_q[i].size() > 0 && !loaded[i]) begin
                    gap_left[i] = int'(src_q[i][0].gap);
                    loaded[i]   = 1'b1;
                end
                if (loaded[i] && gap_left[i] == 0) begin
                    req_valid[i]       = 1'b1;
                    req_last[i]        = src_q[i][0].last;
                    req_data[i*8 +: 8] = src_q[i][0].dat;
                end else begin
                    req_valid[i]       = 1'b0;
                    req_last[i]        = 1'b0;
                    req_data[i*8 +: 8] = 8'h00;
                    if (loaded[i]) gap_left[i]--;
                end
            end
        end
    end

    // Reference model: who owns the channel, bytes sent this grant, idle cycles, next priority.
    bit m_act, m_tev;
    int m_own, m_ptr, m_bytes, m_idle;

    initial begin : compare
        bit prev_ga = 1'b0;
        m_act = 0; m_tev = 0; m_own = 0; m_ptr = 0; m_bytes = 0; m_idle = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("rst_tx_valid", tx_valid, 0);
                chk("rst_req_ready", req_ready, 0);
                chk("rst_tx_data", tx_data, 0);
                chk("rst_grant_active", grant_active, 0);
                chk("rst_grant_id", grant_id, 0);
                chk("rst_timeout_evt", timeout_evt, 0);
                m_act = 0; m_tev = 0; m_own = 0; m_ptr = 0; m_bytes = 0; m_idle = 0;
            end else begin
                chk("tx_valid", tx_valid, m_act ? req_valid[m_own] : 1'b0);
                chk("req_ready", req_ready, (m_act && tx_ready) ? (1 << m_own) : 0);
                chk("tx_data", tx_data, m_act ? req_data[m_own*8 +: 8] : 8'h00);
                chk("grant_active", grant_active, m_act);
                chk("grant_id", grant_id, m_own);
                chk("timeout_evt", timeout_evt, m_tev);
                for (int i = 0; i < N; i++) begin
                    if (req_valid[i] && req_ready[i]) begin
                        acc_cnt[i]++;
                        log_cyc.push_back(cyc);
                        log_src.push_back(i);
                        log_dat.push_back(int'(tx_data));
                        chk("sb_byte_expected", exp_q[i].size() > 0, 1);
                        if (exp_q[i].size() > 0) begin
                            chk($sformatf("sb_data_req%0d", i), tx_data, exp_q[i][0]);
                            exp_q[i].delete(0);
                        end
                    end
                end
                if (timeout_evt) tev_cyc.push_back(cyc);
                m_tev = 0;
                if (!m_act) begin
                    for (int k = 0; k < N; k++) begin
                        if (!m_act && req_valid[(m_ptr + k) % N]) begin
                            m_act = 1; m_own = (m_ptr + k) % N; m_bytes = 0; m_idle = 0;
                        end
                    end
                end else if (req_valid[m_own] && tx_ready) begin
                    m_bytes++;
                    m_idle = 0;
                    if (req_last[m_own] || m_bytes == MB) begin
                        m_act = 0; m_ptr = (m_own + 1) % N;
                    end
                end else if (!req_valid[m_own]) begin
                    m_idle++;
                    if (m_idle == IT) begin
                        m_act = 0; m_ptr = (m_own + 1) % N; m_tev = 1;
                    end
                end
            end
            if (grant_active && !prev_ga) begin
                gnt_cyc.push_back(cyc);
                gnt_id.push_back(int'(grant_id));
            end
            if (!grant_active && prev_ga) rel_cyc.push_back(cyc);
            prev_ga = grant_active;
            cyc++;
        end
    end

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic start_test(output int base, output int lb);
        @(negedge clk);
        #1;
        base = cyc;
        lb   = log_src.size();
    endtask

    task automatic wait_drain(input string name, input int budget);
        int  n    = 0;
        bit  busy = 1'b1;
        while (busy && n < budget) begin
            @(negedge clk);
            #1;
            n++;
            busy = m_act;
            for (int i = 0; i < N; i++) if (src_q[i].size() != 0) busy = 1'b1;
        end
        chk({name, "_drained"}, busy, 0);
    endtask

    task automatic expect_acc(input int s, input int d, input int c);
        exp_src.push_back(s);
        exp_dat.push_back(d);
        exp_cyc.push_back(c);
    endtask

    task automatic chk_log(input string name, input int lb, input int base);
        chk({name, "_count"}, log_src.size() - lb, exp_src.size());
        for (int j = 0; j < exp_src.size() && lb + j < log_src.size(); j++) begin
            chk($sformatf("%s_src%0d", name, j), log_src[lb+j], exp_src[j]);
            chk($sformatf("%s_dat%0d", name, j), log_dat[lb+j], exp_dat[j]);
            chk($sformatf("%s_cyc%0d", name, j), log_cyc[lb+j] - base, exp_cyc[j]);
        end
        exp_src.delete();
        exp_dat.delete();
        exp_cyc.delete();
    endtask

    initial begin : stimulus
        int base, lb, gb, rb, tb;
        tx_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // Single requester, three-byte message.
        start_test(base, lb);
        gb = gnt_cyc.size(); rb = rel_cyc.size();
        push(1, 'h41, 0, 0); push(1, 'h42, 0, 0); push(1, 'h43, 1, 0);
        wait_drain("single", 100);
        for (int j = 0; j < 3; j++) expect_acc(1, 'h41 + j, 1 + j);
        chk_log("single", lb, base);
        chk("single_grant_seen", gnt_cyc.size() > gb, 1);
        chk("single_release_seen", rel_cyc.size() > rb, 1);
        if (gnt_cyc.size() > gb) chk("single_grant_cyc", gnt_cyc[gb] - base, 1);
        if (rel_cyc.size() > rb) chk("single_release_cyc", rel_cyc[rb] - base, 4);

        // rr_ptr now points at 2: it must beat 1 in a tie.
        start_test(base, lb);
        push(1, 'h11, 1, 0); push(2, 'h22, 1, 0);
        wait_drain("ptr", 100);
        expect_acc(2, 'h22, 1); expect_acc(1, 'h11, 3);
        chk_log("ptr", lb, base);

        // All four request together from reset.
        do_reset();
        start_test(base, lb);
        for (int i = 0; i < N; i++) push(i, 'hA0 + i, 1, 0);
        wait_drain("all4", 100);
        for (int i = 0; i < N; i++) expect_acc(i, 'hA0 + i, 1 + 2 * i);
        chk_log("all4", lb, base);

        // 20-byte message is split by the burst cap; requester 2 slips in between.
        do_reset();
        start_test(base, lb);
        for (int j = 0; j < 20; j++) push(0, j, j == 19, 0);
        push(2, 'hC2, 1, 0);
        wait_drain("burst", 200);
        for (int j = 0; j < 16; j++) expect_acc(0, j, 1 + j);
        expect_acc(2, 'hC2, 18);
        for (int j = 16; j < 20; j++) expect_acc(0, j, 20 + j - 16);
        chk_log("burst", lb, base);

        // Owner goes quiet for 8 cycles mid-message: watchdog hands the channel to 1.
        do_reset();
        start_test(base, lb);
        tb = tev_cyc.size();
        push(0, 'h50, 0, 0); push(0, 'h51, 0, 0); push(0, 'h52, 0, 8); push(0, 'h53, 1, 0);
        push(1, 'h61, 1, 0);
        wait_drain("tmo", 200);
        expect_acc(0, 'h50, 1); expect_acc(0, 'h51, 2); expect_acc(1, 'h61, 12);
        expect_acc(0, 'h52, 14); expect_acc(0, 'h53, 15);
        chk_log("tmo", lb, base);
        chk("tmo_evt_count", tev_cyc.size() - tb, 1);
        if (tev_cyc.size() > tb) chk("tmo_evt_cyc", tev_cyc[tb] - base, 11);

        // UART back-pressure for 50 cycles never trips the watchdog.
        do_reset();
        start_test(base, lb);
        tb = tev_cyc.size();
        push(0, 'h70, 0, 0); push(0, 'h71, 0, 0); push(0, 'h72, 1, 0);
        push(1, 'h91, 1, 0);
        repeat (3) @(posedge clk);
        #1 tx_ready = 1'b0;
        repeat (50) @(posedge clk);
        #1 tx_ready = 1'b1;
        wait_drain("bp", 200);
        expect_acc(0, 'h70, 1); expect_acc(0, 'h71, 52); expect_acc(0, 'h72, 53);
        expect_acc(1, 'h91, 55);
        chk_log("bp", lb, base);
        chk("bp_evt_count", tev_cyc.size() - tb, 0);

        // Reset lands mid-cycle while byte 0x83 is offered; it must be sent exactly once later.
        do_reset();
        start_test(base, lb);
        for (int j = 0; j < 6; j++) push(0, 'h80 + j, j == 5, 0);
        push(1, 'hB1, 1, 0);
        repeat (5) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("async_tx_valid", tx_valid, 0);
        chk("async_req_ready", req_ready, 0);
        chk("async_tx_data", tx_data, 0);
        chk("async_grant_active", grant_active, 0);
        chk("async_grant_id", grant_id, 0);
        chk("async_timeout_evt", timeout_evt, 0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        wait_drain("midrst", 100);
        for (int j = 0; j < 3; j++) expect_acc(0, 'h80 + j, 1 + j);
        for (int j = 3; j < 6; j++) expect_acc(0, 'h80 + j, 4 + j);
        expect_acc(1, 'hB1, 11);
        chk_log("midrst", lb, base);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d of %0d checks passed", n_pass, n_chk);
        $fatal(1);
    end
endmodule
